pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder; next generation of the team's fixed 4-bit combinational CLA.
- Splits a WIDTH-bit add into BLOCK-bit lookahead groups, with one register stage per group.
- Uses a valid/ready handshake with backpressure.
- Used wherever wide adds must close timing at clk rate.

---
 rtl/pipelined_cla_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one BLOCK-bit lookahead group per register stage,
// valid/ready handshake with global stall. Optional signed overflow output: PIPELINED_CLA_OVF_EN.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout
`ifdef PIPELINED_CLA_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NSTAGE = WIDTH / BLOCK;

  if (BLOCK == 0 || WIDTH == 0 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Returns carries c[0..BLOCK] of one group, each expanded as a flat sum of products.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] a,
                                               input logic [BLOCK-1:0] b,
                                               input logic             c0);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             prod;
    int unsigned      j;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      prod = 1'b1;
      for (int unsigned m = 0; m <= i; m++) begin
        j      = i - m;
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & c0);
    end
    return c;
  endfunction

  // Each stage consumes the low BLOCK bits of its operand stream and forwards the rest,
  // so the operand registers shrink and the sum register grows by BLOCK per stage.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned RIN = WIDTH - BLOCK * k;
    localparam int unsigned SW  = BLOCK * (k + 1);

    logic [RIN-1:0]   src_a;
    logic [RIN-1:0]   src_b;
    logic             src_c;
    logic             src_v;
    logic [BLOCK:0]   cv;
    logic [BLOCK-1:0] grp_sum;
    logic [SW-1:0]    s_d;
    logic [SW-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign src_a = in1;
      assign src_b = in2;
      assign src_c = cin;
      assign src_v = in_valid;
      assign s_d   = grp_sum;
    end else begin : g_src
      assign src_a = g_stage[k-1].g_fwd.a_q;
      assign src_b = g_stage[k-1].g_fwd.b_q;
      assign src_c = g_stage[k-1].c_q;
      assign src_v = g_stage[k-1].v_q;
      assign s_d   = {grp_sum, g_stage[k-1].s_q};
    end

    always_comb begin
      cv      = lookahead(src_a[BLOCK-1:0], src_b[BLOCK-1:0], src_c);
      grp_sum = src_a[BLOCK-1:0] ^ src_b[BLOCK-1:0] ^ cv[BLOCK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= src_v;
        c_q <= cv[BLOCK];
        s_q <= s_d;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      logic [RIN-BLOCK-1:0] a_q;
      logic [RIN-BLOCK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[RIN-1:BLOCK];
          b_q <= src_b[RIN-1:BLOCK];
        end
      end
    end
  end

  assign out       = g_stage[NSTAGE-1].s_q;
  assign cout      = g_stage[NSTAGE-1].c_q;
  assign out_valid = g_stage[NSTAGE-1].v_q;

`ifdef PIPELINED_CLA_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (advance) begin
      overflow <= g_stage[NSTAGE-1].cv[BLOCK-1] ^ g_stage[NSTAGE-1].cv[BLOCK];
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a 16/4 instance (4 stages) and a 4/4 instance (1 stage).
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v16, rdy16, ir16, ov16, cin16, co16;
  logic [15:0] a16, b16, s16;
  logic        v4, rdy4, ir4, ov4, cin4, co4;
  logic [3:0]  a4, b4, s4;
`ifdef PIPELINED_CLA_OVF_EN
  logic        of16, of4;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in1(a16), .in2(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(rdy16), .out(s16), .cout(co16)
`ifdef PIPELINED_CLA_OVF_EN
    , .overflow(of16)
`endif
  );

  pipelined_cla_adder #(.WIDTH(4), .BLOCK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in1(a4), .in2(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(rdy4), .out(s4), .cout(co4)
`ifdef PIPELINED_CLA_OVF_EN
    , .overflow(of4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated add on the 16-bit pipe: result must appear on the 4th edge, then drop.
  task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic [15:0] exp_s, input logic exp_c,
                            input logic exp_ovf);
    a16 = a; b16 = b; cin16 = c; v16 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      v16 = 1'b0;
      if (n < 4) check({tag, "_early_valid"}, 32'(ov16), 32'd0);
    end
    check({tag, "_valid"}, 32'(ov16), 32'd1);
    check({tag, "_sum"}, 32'(s16), 32'(exp_s));
    check({tag, "_cout"}, 32'(co16), 32'(exp_c));
`ifdef PIPELINED_CLA_OVF_EN
    check({tag, "_ovf"}, 32'(of16), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x");
`endif
    step();
    check({tag, "_drop"}, 32'(ov16), 32'd0);
  endtask

  logic [3:0]  t1a [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110};
  logic [3:0]  t1b [4] = '{4'b1110, 4'b1010, 4'b0111, 4'b0110};
  logic [3:0]  t1s [4] = '{4'b0000, 4'b1100, 4'b1001, 4'b1100};
  logic        t1c [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0]  pat = 4'b1001;
  logic [16:0] bexp [4];
  logic [16:0] q [$];
  logic [16:0] expv, prev;
  logic        stalled;
  int          sent, got, stall_cycles;

  initial begin
    rst_n = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; rdy16 = 1'b1;
    v4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; rdy4  = 1'b1;
    #2;
    check("rst_valid16", 32'(ov16), 32'd0);
    check("rst_out16", 32'(s16), 32'd0);
    check("rst_cout16", 32'(co16), 32'd0);
    check("rst_ready16", 32'(ir16), 32'd1);
    check("rst_valid4", 32'(ov4), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // NSTAGE=1 back-to-back stream
    for (int i = 0; i < 4; i++) begin
      a4 = t1a[i]; b4 = t1b[i]; v4 = 1'b1;
      step();
      check("t1_valid", 32'(ov4), 32'd1);
      check("t1_sum", 32'(s4), 32'(t1s[i]));
      check("t1_cout", 32'(co4), 32'(t1c[i]));
    end
    v4 = 1'b0;
    step();
    check("t1_drop", 32'(ov4), 32'd0);

    run_single("wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_single("plain", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_single("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Bubbles: in_valid 1,0,0,1 reappears on out_valid three steps later
    for (int cyc = 0; cyc < 8; cyc++) begin
      v16 = (cyc < 4) ? pat[cyc] : 1'b0;
      a16 = 16'h1111 * 16'(cyc + 1); b16 = 16'h0F0F; cin16 = 1'b1;
      if (cyc < 4) bexp[cyc] = {1'b0, a16} + {1'b0, b16} + 17'd1;
      step();
      if (cyc >= 3 && cyc <= 6) begin
        check("bub_valid", 32'(ov16), 32'(pat[cyc-3]));
        if (pat[cyc-3]) check("bub_data", 32'({co16, s16}), 32'(bexp[cyc-3]));
      end else begin
        check("bub_idle", 32'(ov16), 32'd0);
      end
    end

    // Backpressure: 8 random adds, out_ready low for 3 cycles mid-stream
    sent = 0; got = 0; stall_cycles = 0; stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      rdy16 = !(cyc >= 4 && cyc <= 6);
      v16 = (sent < 8);
      if (v16) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
      #1;
      check("bp_in_ready", 32'(ir16), 32'(!ov16 || rdy16));
      if (stalled) check("bp_stable", 32'({co16, s16}), 32'(prev));
      if (ov16 && !rdy16) stall_cycles++;
      if (ov16 && rdy16) begin
        if (q.size() == 0) begin
          check("bp_spurious", 32'(ov16), 32'd0);
        end else begin
          expv = q.pop_front();
          check("bp_data", 32'({co16, s16}), 32'(expv));
          got++;
        end
      end
      if (v16 && ir16) begin
        q.push_back({1'b0, a16} + {1'b0, b16} + {16'd0, cin16});
        sent++;
      end
      stalled = ov16 && !rdy16;
      prev = {co16, s16};
      step();
    end
    check("bp_received", 32'(got), 32'd8);
    check("bp_queue_empty", 32'(q.size()), 32'd0);
    check("bp_stall_cycles", 32'(stall_cycles), 32'd3);
    v16 = 1'b0; rdy16 = 1'b1;
    step();
    check("bp_drained", 32'(ov16), 32'd0);

    // Asynchronous reset with results in flight
    for (int i = 0; i < 4; i++) begin
      a16 = 16'h0100 * 16'(i + 1); b16 = 16'h0011; cin16 = 1'b0; v16 = 1'b1;
      step();
    end
    v16 = 1'b0;
    check("rst_pre_valid", 32'(ov16), 32'd1);
    check("rst_pre_sum", 32'(s16), 32'h0111);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ov16), 32'd0);
    check("arst_out", 32'(s16), 32'd0);
    check("arst_cout", 32'(co16), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("arst_no_stale", 32'(ov16), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
